// File: rtl/icb_ext_sram_slave.sv
// ICB three-channel slave in front of a single-port synchronous word SRAM.
// Serves single-beat and burst reads/writes, with in-order responses from a small FIFO.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RD    | issuing one read beat per cycle while the response FIFO has room
// WR    | accepting write beats while the response FIFO has room
module icb_ext_sram_slave #(
    parameter int BUS_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int RSP_FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic                    cmd_read,
    input  logic [2:0]              cmd_len,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [BUS_WIDTH-1:0]    wdata,
    input  logic [BUS_WIDTH/8-1:0]  wmask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [BUS_WIDTH-1:0]    rsp_rdata,
    output logic                    rsp_err
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);
    localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(4 * MEM_DEPTH);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(RSP_FIFO_DEPTH);
    localparam logic [CNT_W:0] OCC_FULL = (CNT_W+1)'(RSP_FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [3:0]              beats_left;
    logic                    inflight;
    logic                    inflight_err;
    logic [IDX_W-1:0]        word_idx;
    logic                    beat_err;
    logic                    last_beat;
    logic                    rd_issue;
    logic                    wr_hs;

    logic [BUS_WIDTH-1:0]    mem [MEM_DEPTH];
    logic [BUS_WIDTH-1:0]    mem_rdata;

    logic [BUS_WIDTH-1:0]    fifo_data [RSP_FIFO_DEPTH];
    logic                    fifo_err [RSP_FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W:0]          occupancy;
    logic                    push;
    logic                    pop;
    logic [BUS_WIDTH-1:0]    push_data;
    logic                    push_err;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign offset    = addr_q - BASE_ADDR;
    assign word_idx  = offset[IDX_W+1:2];
    assign beat_err  = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) ||
                       ({1'b0, offset} >= MEM_BYTES);
    assign last_beat = (beats_left == 4'd1);

    // A read issued last cycle still owns a FIFO slot until it is pushed.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};

    assign cmd_ready = !rst && (state == S_IDLE);
    assign w_ready   = !rst && (state == S_WR) && (fifo_count < FIFO_FULL);
    assign rd_issue  = !rst && (state == S_RD) && (occupancy < OCC_FULL);
    assign wr_hs     = w_valid && w_ready;

    assign push      = wr_hs || inflight;
    assign push_data = (wr_hs || inflight_err) ? '0 : mem_rdata;
    assign push_err  = wr_hs ? beat_err : inflight_err;

    assign rsp_valid = !rst && (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_rdata = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_err   = rsp_valid && fifo_err[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            beats_left   <= '0;
            inflight     <= 1'b0;
            inflight_err <= 1'b0;
        end else begin
            inflight     <= rd_issue;
            inflight_err <= rd_issue && beat_err;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q     <= cmd_addr;
                        beats_left <= {1'b0, cmd_len} + 4'd1;
                        state      <= cmd_read ? S_RD : S_WR;
                    end
                end
                S_RD: begin
                    if (rd_issue) begin
                        addr_q     <= addr_q + ADDR_WIDTH'(4);
                        beats_left <= beats_left - 4'd1;
                        if (last_beat) state <= S_IDLE;
                    end
                end
                S_WR: begin
                    if (wr_hs) begin
                        addr_q     <= addr_q + ADDR_WIDTH'(4);
                        beats_left <= beats_left - 4'd1;
                        if (last_beat) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Error beats never touch the array, so out-of-range addresses cannot alias.
    always_ff @(posedge clk) begin
        if (rd_issue && !beat_err) mem_rdata <= mem[word_idx];
        if (wr_hs && !beat_err) begin
            for (int b = 0; b < BUS_WIDTH/8; b++) begin
                if (wmask[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_err[wr_ptr]  <= push_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
